// File: rtl/icache_tag_ctrl.sv
// rtl/icache_tag_ctrl.sv - direct-mapped instruction cache tag controller
// Tracks 16 line valid bits, probes the tag SRAM and sequences refills.
module icache_tag_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_addr,
  input  logic        flush,
  output logic        dfp_read,
  output logic [31:0] dfp_addr,
  input  logic        dfp_resp,
  output logic        tag_csb0,
  output logic        tag_web0,
  output logic [3:0]  tag_addr0,
  output logic [23:0] tag_din0,
  input  logic [23:0] tag_dout0
);

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, WRITE, REPLAY} state_t;

  state_t      state, next_state;
  logic [15:0] valid;
  logic [31:0] addr_q;
  logic [3:0]  idx;
  logic        hit;
  logic        accept;
  logic        unused;

  assign idx       = addr_q[8:5];
  assign hit       = (state == LOOKUP) && valid[idx] && (tag_dout0[22:0] == addr_q[31:9]);
  assign accept    = req_valid && req_ready;
  assign resp_addr = addr_q;
  assign dfp_addr  = {addr_q[31:5], 5'b0};
  assign tag_din0  = {1'b0, addr_q[31:9]};
  assign unused    = tag_dout0[23];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = LOOKUP;
      LOOKUP:  next_state = hit ? (accept ? LOOKUP : IDLE) : REFILL;
      REFILL:  if (dfp_resp) next_state = WRITE;
      WRITE:   next_state = REPLAY;
      REPLAY:  next_state = LOOKUP;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are gated by rst so nothing leaks to the SRAM or requester during reset.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    dfp_read   = 1'b0;
    tag_csb0   = 1'b1;
    tag_web0   = 1'b1;
    tag_addr0  = idx;
    if (!rst) begin
      case (state)
        IDLE: begin
          req_ready = 1'b1;
          if (req_valid) begin
            tag_csb0  = 1'b0;
            tag_addr0 = req_addr[8:5];
          end
        end
        LOOKUP: begin
          if (hit) begin
            resp_valid = 1'b1;
            req_ready  = 1'b1;
            if (req_valid) begin
              tag_csb0  = 1'b0;
              tag_addr0 = req_addr[8:5];
            end
          end
        end
        REFILL:  dfp_read = 1'b1;
        WRITE: begin
          tag_csb0 = 1'b0;
          tag_web0 = 1'b0;
        end
        REPLAY:  tag_csb0 = 1'b0;
        default: ;
      endcase
    end
  end

  // The WRITE set is OR-ed after the flush clear so the fresh line survives a coincident flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      valid <= '0;
    else if (flush || state == WRITE)
      valid <= (flush ? 16'h0 : valid) | ((state == WRITE) ? (16'h1 << idx) : 16'h0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         addr_q <= '0;
    else if (accept) addr_q <= req_addr;
  end

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// tb/tb_icache_tag_ctrl.sv - directed self-checking bench for icache_tag_ctrl
// Inputs change just after the falling edge; outputs are sampled there too.
module tb_icache_tag_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready, resp_valid, dfp_read;
  logic [31:0] resp_addr, dfp_addr;
  logic        flush = 1'b0;
  logic        dfp_resp = 1'b0;
  logic        tag_csb0, tag_web0;
  logic [3:0]  tag_addr0;
  logic [23:0] tag_din0;
  logic [23:0] tag_dout0;
  logic [23:0] mem [16];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  icache_tag_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_addr(resp_addr),
    .flush(flush), .dfp_read(dfp_read), .dfp_addr(dfp_addr), .dfp_resp(dfp_resp),
    .tag_csb0(tag_csb0), .tag_web0(tag_web0), .tag_addr0(tag_addr0),
    .tag_din0(tag_din0), .tag_dout0(tag_dout0)
  );

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 24'h0;
    tag_dout0 = 24'h0;
  end

  always @(posedge clk) begin
    if (!tag_csb0 && !tag_web0) mem[tag_addr0] <= tag_din0;
    if (!tag_csb0 && tag_web0)  tag_dout0 <= mem[tag_addr0];
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Drives the tail of a refill from the first REFILL cycle back to IDLE.
  task automatic finish_refill();
    dfp_resp = 1'b1;
    step();
    dfp_resp = 1'b0;
    step();
    step();
    step();
  endtask

  task automatic test_reset();
    repeat (2) step();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b expected 0", resp_valid); end
    checks++; if (dfp_read !== 1'b0) begin errors++; $display("FAIL reset_dfp_read got %b expected 0", dfp_read); end
    checks++; if ({tag_csb0, tag_web0} !== 2'b11) begin errors++; $display("FAIL reset_sram_idle got %b expected 11", {tag_csb0, tag_web0}); end
    checks++; if (resp_addr !== 32'h0) begin errors++; $display("FAIL reset_resp_addr got %h expected 00000000", resp_addr); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b expected 1", req_ready); end
    step();
  endtask

  task automatic test_cold_miss();
    req_valid = 1'b1; req_addr = 32'h0000_1000;
    #1;
    checks++; if ({tag_csb0, tag_web0, tag_addr0} !== 6'b01_0000) begin errors++; $display("FAIL cold_probe got %b expected 010000", {tag_csb0, tag_web0, tag_addr0}); end
    step();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL cold_lookup_resp got %b expected 0", resp_valid); end
    req_valid = 1'b0;
    step();
    checks++; if (dfp_read !== 1'b1) begin errors++; $display("FAIL cold_dfp_read got %b expected 1", dfp_read); end
    checks++; if (dfp_addr !== 32'h0000_1000) begin errors++; $display("FAIL cold_dfp_addr got %h expected 00001000", dfp_addr); end
    step();
    step();
    checks++; if ({dfp_read, dfp_addr} !== {1'b1, 32'h0000_1000}) begin errors++; $display("FAIL cold_refill_hold got %b/%h expected 1/00001000", dfp_read, dfp_addr); end
    dfp_resp = 1'b1;
    step();
    dfp_resp = 1'b0;
    checks++; if ({tag_csb0, tag_web0, tag_addr0} !== 6'b00_0000) begin errors++; $display("FAIL cold_write_ctl got %b expected 000000", {tag_csb0, tag_web0, tag_addr0}); end
    checks++; if (tag_din0 !== 24'h000008) begin errors++; $display("FAIL cold_write_din got %h expected 000008", tag_din0); end
    step();
    checks++; if ({resp_valid, tag_csb0, tag_web0} !== 3'b001) begin errors++; $display("FAIL cold_replay got %b expected 001", {resp_valid, tag_csb0, tag_web0}); end
    step();
    checks++; if ({resp_valid, resp_addr} !== {1'b1, 32'h0000_1000}) begin errors++; $display("FAIL cold_resp got %b/%h expected 1/00001000", resp_valid, resp_addr); end
    step();
    checks++; if ({resp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL cold_back_idle got %b expected 01", {resp_valid, req_ready}); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    addrs[0] = 32'h0000_1000; addrs[1] = 32'h0000_1004; addrs[2] = 32'h0000_101C;
    mem[0][23] = 1'b1;
    req_valid = 1'b1; req_addr = addrs[0];
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({resp_valid, resp_addr} !== {1'b1, addrs[i]}) begin errors++; $display("FAIL b2b_resp_%0d got %b/%h expected 1/%h", i, resp_valid, resp_addr, addrs[i]); end
      checks++; if ({req_ready, dfp_read} !== 2'b10) begin errors++; $display("FAIL b2b_ready_%0d got %b expected 10", i, {req_ready, dfp_read}); end
      if (i < 2) req_addr = addrs[i+1];
      else req_valid = 1'b0;
    end
    step();
    checks++; if ({resp_valid, dfp_read} !== 2'b00) begin errors++; $display("FAIL b2b_end got %b expected 00", {resp_valid, dfp_read}); end
  endtask

  task automatic test_conflict();
    req_valid = 1'b1; req_addr = 32'h0000_1200;
    step();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL conflict_miss got %b expected 0", resp_valid); end
    req_valid = 1'b0;
    step();
    checks++; if ({dfp_read, dfp_addr} !== {1'b1, 32'h0000_1200}) begin errors++; $display("FAIL conflict_dfp got %b/%h expected 1/00001200", dfp_read, dfp_addr); end
    dfp_resp = 1'b1;
    step();
    dfp_resp = 1'b0;
    checks++; if ({tag_web0, tag_addr0, tag_din0} !== {1'b0, 4'h0, 24'h000009}) begin errors++; $display("FAIL conflict_write got %b/%h/%h expected 0/0/000009", tag_web0, tag_addr0, tag_din0); end
    step();
    step();
    checks++; if ({resp_valid, resp_addr} !== {1'b1, 32'h0000_1200}) begin errors++; $display("FAIL conflict_resp got %b/%h expected 1/00001200", resp_valid, resp_addr); end
    step();
    req_valid = 1'b1; req_addr = 32'h0000_1000;
    step();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL conflict_evicted got %b expected 0", resp_valid); end
    req_valid = 1'b0;
    step();
    checks++; if ({dfp_read, dfp_addr} !== {1'b1, 32'h0000_1000}) begin errors++; $display("FAIL conflict_refetch got %b/%h expected 1/00001000", dfp_read, dfp_addr); end
    finish_refill();
  endtask

  task automatic test_flush();
    req_valid = 1'b1; req_addr = 32'h0000_01E0;
    step();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL idx15_cold_miss got %b expected 0", resp_valid); end
    req_valid = 1'b0;
    step();
    checks++; if ({dfp_read, dfp_addr} !== {1'b1, 32'h0000_01E0}) begin errors++; $display("FAIL idx15_dfp got %b/%h expected 1/000001e0", dfp_read, dfp_addr); end
    dfp_resp = 1'b1;
    step();
    dfp_resp = 1'b0;
    checks++; if ({tag_addr0, tag_din0} !== {4'hF, 24'h000000}) begin errors++; $display("FAIL idx15_write got %h/%h expected f/000000", tag_addr0, tag_din0); end
    step();
    step();
    checks++; if ({resp_valid, resp_addr} !== {1'b1, 32'h0000_01E0}) begin errors++; $display("FAIL idx15_resp got %b/%h expected 1/000001e0", resp_valid, resp_addr); end
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    req_valid = 1'b1; req_addr = 32'h0000_1000;
    step();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL flush_miss_0 got %b expected 0", resp_valid); end
    req_valid = 1'b0;
    step();
    checks++; if (dfp_read !== 1'b1) begin errors++; $display("FAIL flush_refill_0 got %b expected 1", dfp_read); end
    dfp_resp = 1'b1;
    step();
    dfp_resp = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    checks++; if ({resp_valid, resp_addr} !== {1'b1, 32'h0000_1000}) begin errors++; $display("FAIL flush_write_wins got %b/%h expected 1/00001000", resp_valid, resp_addr); end
    step();
    req_valid = 1'b1; req_addr = 32'h0000_01E0;
    step();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL flush_miss_15 got %b expected 0", resp_valid); end
    req_valid = 1'b0;
    step();
    checks++; if (dfp_read !== 1'b1) begin errors++; $display("FAIL flush_refill_15 got %b expected 1", dfp_read); end
    finish_refill();
  endtask

  task automatic test_reset_mid_refill();
    req_valid = 1'b1; req_addr = 32'h0000_2000;
    step();
    req_valid = 1'b0;
    step();
    checks++; if (dfp_read !== 1'b1) begin errors++; $display("FAIL midrst_refill got %b expected 1", dfp_read); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({dfp_read, resp_valid, tag_csb0, tag_web0} !== 4'b0011) begin errors++; $display("FAIL midrst_async got %b expected 0011", {dfp_read, resp_valid, tag_csb0, tag_web0}); end
    step();
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b expected 1", req_ready); end
    dfp_resp = 1'b1;
    step();
    dfp_resp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({tag_web0, resp_valid, dfp_read} !== 3'b100) begin errors++; $display("FAIL midrst_stale_%0d got %b expected 100", i, {tag_web0, resp_valid, dfp_read}); end
      step();
    end
    req_valid = 1'b1; req_addr = 32'h0000_1000;
    step();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid_cleared got %b expected 0", resp_valid); end
    req_valid = 1'b0;
    step();
    finish_refill();
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_conflict();
    test_flush();
    test_reset_mid_refill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_tag_ctrl.md
ICACHE_TAG_CTRL -- requirements
Module: icache_tag_ctrl

Interface
REQ-001 SHALL have a single clock, clk: input, 1 bit, rising-edge clock for all state.
REQ-002 SHALL have rst: input, 1 bit; reset is asynchronous and active-high.
REQ-003 SHALL have req_valid: input, 1 bit; a fetch request is present.
REQ-004 SHALL have req_addr: input, 32 bits; fetch byte address, with tag = [31:9], index = [8:5] and offset = [4:0].
REQ-005 SHALL have req_ready: output, 1 bit; a request is accepted when req_valid && req_ready.
REQ-006 SHALL have resp_valid: output, 1 bit; one-cycle pulse meaning the line holding resp_addr is resident.
REQ-007 SHALL have resp_addr: output, 32 bits; the latched address of the responding request.
REQ-008 SHALL have flush: input, 1 bit; invalidate all entries.
REQ-009 SHALL have dfp_read: output, 1 bit; line refill request to the lower level.
REQ-010 SHALL have dfp_addr: output, 32 bits; line-aligned refill address {addr[31:5], 5'b0}.
REQ-011 SHALL have dfp_resp: input, 1 bit; the refill is complete.
REQ-012 SHALL have tag_csb0: output, 1 bit; tag SRAM chip select, active low.
REQ-013 SHALL have tag_web0: output, 1 bit; tag SRAM write enable, active low.
REQ-014 SHALL have tag_addr0: output, 4 bits; tag SRAM word address.
REQ-015 SHALL have tag_din0: output, 24 bits; tag SRAM write data.
REQ-016 SHALL have tag_dout0: input, 24 bits; tag SRAM read data, valid the cycle after a read is issued.

Function
REQ-017 SHALL implement the FSM states IDLE, LOOKUP, REFILL, WRITE and REPLAY.
REQ-018 SHALL hold 16 valid bits in flops, because the tag SRAM has no reset.
REQ-019 SHALL drive tag_csb0=1 and tag_web0=1 in every cycle with no SRAM access.
REQ-020 SHALL drive req_ready = (state==IDLE) || (state==LOOKUP && hit).
REQ-021 SHALL, on accept, latch req_addr and in the same cycle drive tag_csb0=0, tag_web0=1, tag_addr0=req_addr[8:5], then enter LOOKUP.
REQ-022 SHALL, in LOOKUP, compute hit = valid[idx] && tag_dout0[22:0]==addr[31:9]; tag_dout0[23] is ignored.
REQ-023 SHALL, in LOOKUP on a hit, assert resp_valid for one cycle with resp_addr = latched address.
REQ-024 SHALL, in LOOKUP on a hit, go to LOOKUP if a new request is accepted, else to IDLE, giving one response per cycle on back-to-back hits.
REQ-025 SHALL, in LOOKUP on a miss, enter REFILL with resp_valid=0.
REQ-026 SHALL, in REFILL, hold dfp_read=1 and dfp_addr stable until the cycle dfp_resp=1, then enter WRITE.
REQ-027 SHALL ignore dfp_resp in every state other than REFILL.
REQ-028 SHALL, in WRITE, drive tag_csb0=0, tag_web0=0, tag_addr0=idx, tag_din0={1'b0, tag}, set valid[idx] at the clock edge, and enter REPLAY.
REQ-029 SHALL, in REPLAY, issue a read of idx and enter LOOKUP, which then hits.
REQ-030 SHALL give a miss-to-response latency of 1 (lookup) + N (refill wait) + 1 (write) + 1 (replay) + 1 (lookup) cycles.
REQ-031 SHALL clear all valid bits at the clock edge whenever flush=1, in any state.
REQ-032 SHALL let the set win over the flush clear for that index when flush and WRITE occur in the same cycle.
REQ-033 SHALL evaluate a LOOKUP coincident with flush using the pre-edge valid bits.
REQ-034 SHALL let a refill in progress during flush complete normally.
REQ-035 SHALL be direct-mapped: a miss overwrites the tag at idx unconditionally.
REQ-036 SHALL treat index 15 as an ordinary entry with no special case.

Reset
REQ-037 SHALL, while rst=1, immediately (without a clock edge) force state=IDLE, all valid bits=0, resp_valid=0, dfp_read=0, tag_csb0=1, tag_web0=1, and all latched addresses to 0.
REQ-038 SHALL make req_ready=1 in the first cycle after rst deasserts.
REQ-039 SHALL abandon a refill in progress when rst is asserted; a dfp_resp arriving later SHALL cause no SRAM write and no response.

Verification
REQ-040 Cold miss: after reset, request 0x0000_1000 -> dfp_read=1 with dfp_addr=0x0000_1000; dfp_resp 3 cycles later -> WRITE drives tag_addr0=0, tag_din0=0x000008; resp_valid=1 with resp_addr=0x0000_1000 two cycles after WRITE.
REQ-041 Back-to-back hits: with 0x1000 resident, requests 0x1000, 0x1004, 0x101C on consecutive cycles -> resp_valid high for 3 consecutive cycles, dfp_read never asserted.
REQ-042 Conflict: 0x1000 resident, then request 0x1200 (idx 0, tag 0x9) -> miss and tag_din0=0x000009; a following request to 0x1000 misses again.
REQ-043 Flush: entries 0 and 15 (0x0000_01E0) resident, flush pulse for one cycle -> next requests to 0x1000 and 0x01E0 both miss.
REQ-044 Reset mid-refill: rst asserted in REFILL -> dfp_read falls without a clock edge and req_ready=1 after release; a dfp_resp pulse afterwards -> no tag_web0=0 and no resp_valid.
